// File: rtl/fpga_ctrl_pkg.sv
// Shared types and helpers for the fpga program executor run controller.
package fpga_ctrl_pkg;

    localparam int DefaultWordWidth = 12;

    typedef logic [DefaultWordWidth-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits for a beat counter that must reach the larger of the two channel sizes.
    function automatic int count_width(input int a, input int b);
        return index_width(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/fpga_beat_counter.sv
// Beat counter with synchronous clear, parallel load, increment and a flag
// that marks the terminal (last) count of a transfer.
module fpga_beat_counter #(
    parameter int Width    = 3,
    parameter int Terminal = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             inc,
    output logic [Width-1:0] count,
    output logic             last
);

    localparam logic [Width-1:0] TerminalValue = Width'(Terminal);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {Width{1'b0}};
        end else if (load) begin
            count_d = load_value;
        end else if (inc) begin
            count_d = count_q + Width'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {Width{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == TerminalValue);

endmodule

// File: rtl/fpga_run_controller.sv
// Sequences one run of the fpga program executor: load inputs, reset/run, drain outputs.
// Optional step watchdog enabled by defining FPGA_CTRL_WATCHDOG_EN.
module fpga_run_controller
    import fpga_ctrl_pkg::*;
#(
    parameter int MemoryElementWidth = DefaultWordWidth,
    parameter int NIn                = 3,
    parameter int NOut               = 6,
    parameter int MaxSteps           = 1024,
    localparam int CntW              = count_width(NIn, NOut)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MemoryElementWidth-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MemoryElementWidth-1:0] out_data,
    output logic                          prog_in_we,
    output logic [CntW-1:0]               prog_in_addr,
    output logic [MemoryElementWidth-1:0] prog_in_data,
    output logic                          prog_reset,
    input  logic                          prog_finished,
    input  logic                          prog_success,
    output logic [CntW-1:0]               prog_out_addr,
    input  logic [MemoryElementWidth-1:0] prog_out_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout
);

    if (MaxSteps < 1) begin : g_bad_max_steps
        $error("fpga_run_controller: MaxSteps must be at least 1");
    end

    state_t          state_q;
    state_t          state_d;
    logic            pass_q;
    logic            pass_d;
    logic            in_beat;
    logic            out_beat;
    logic            load_clear;
    logic            drain_clear;
    logic            load_last;
    logic            drain_last;
    logic [CntW-1:0] load_cnt;
    logic [CntW-1:0] drain_cnt;

`ifdef FPGA_CTRL_WATCHDOG_EN
    localparam int              StepW    = index_width(MaxSteps + 1);
    localparam logic [StepW-1:0] StepMax  = StepW'(MaxSteps);
    localparam logic [StepW-1:0] StepLast = StepW'(MaxSteps - 1);

    logic             timeout_q;
    logic             timeout_d;
    logic [StepW-1:0] steps_q;
    logic [StepW-1:0] steps_d;
`endif

    assign in_beat  = in_valid & in_ready;
    assign out_beat = out_valid & out_ready;

    fpga_beat_counter #(
        .Width    (CntW),
        .Terminal ((NIn > 0) ? NIn - 1 : 0)
    ) u_load_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (load_clear),
        .load       (1'b0),
        .load_value ({CntW{1'b0}}),
        .inc        (in_beat),
        .count      (load_cnt),
        .last       (load_last)
    );

    fpga_beat_counter #(
        .Width    (CntW),
        .Terminal ((NOut > 0) ? NOut - 1 : 0)
    ) u_drain_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (drain_clear),
        .load       (1'b0),
        .load_value ({CntW{1'b0}}),
        .inc        (out_beat),
        .count      (drain_cnt),
        .last       (drain_last)
    );

    // Run sequencer: next state, pass/timeout latches and counter clears.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        load_clear  = 1'b0;
        drain_clear = 1'b0;
`ifdef FPGA_CTRL_WATCHDOG_EN
        timeout_d   = timeout_q;
        steps_d     = steps_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = (NIn == 0) ? START : LOAD;
                    pass_d      = 1'b0;
                    load_clear  = 1'b1;
                    drain_clear = 1'b1;
`ifdef FPGA_CTRL_WATCHDOG_EN
                    timeout_d   = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            LOAD: begin
                if (in_beat && load_last) begin
                    state_d    = START;
                    load_clear = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            START: begin
                state_d = RUN;
`ifdef FPGA_CTRL_WATCHDOG_EN
                steps_d = {StepW{1'b0}};
`endif
            end
            RUN: begin
`ifdef FPGA_CTRL_WATCHDOG_EN
                steps_d = (steps_q == StepMax) ? steps_q : steps_q + StepW'(1);
`endif
                // A finish on the watchdog's last step still counts as a finish.
                if (prog_finished) begin
                    pass_d  = prog_success;
                    state_d = (NOut == 0) ? DONE : DRAIN;
`ifdef FPGA_CTRL_WATCHDOG_EN
                end else if (steps_q == StepLast) begin
                    state_d   = DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            DRAIN: begin
                if (out_beat && drain_last) begin
                    state_d     = DONE;
                    drain_clear = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pass registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

`ifdef FPGA_CTRL_WATCHDOG_EN
    // Watchdog step counter and timeout latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            steps_q   <= {StepW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            steps_q   <= steps_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = !reset && timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Handshakes and status are forced inactive while reset is held.
    assign in_ready      = !reset && (state_q == LOAD);
    assign out_valid     = !reset && (state_q == DRAIN);
    assign out_data      = prog_out_data;
    assign prog_in_we    = in_beat;
    assign prog_in_addr  = load_cnt;
    assign prog_in_data  = in_data;
    assign prog_reset    = reset || (state_q == START);
    assign prog_out_addr = drain_cnt;
    assign busy          = !reset && (state_q != IDLE) && (state_q != DONE);
    assign done          = !reset && (state_q == DONE);
    assign pass          = !reset && pass_q;

endmodule

// File: tb/tb_fpga_run_controller.sv
// Randomized self-checking bench for fpga_run_controller with a behavioural executor.
// The watchdog cases run only when FPGA_CTRL_WATCHDOG_EN is defined.
module tb_fpga_run_controller;

    localparam int MEW = 12;
    localparam int NIN = 3;
    localparam int NOUT = 6;
    localparam int AW = 3;
`ifdef FPGA_CTRL_WATCHDOG_EN
    localparam int MAXS = 16;
`else
    localparam int MAXS = 1024;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [MEW-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [MEW-1:0] out_data;
    logic           prog_in_we;
    logic [AW-1:0]  prog_in_addr;
    logic [MEW-1:0] prog_in_data;
    logic           prog_reset;
    logic           prog_finished;
    logic           prog_success;
    logic [AW-1:0]  prog_out_addr;
    logic [MEW-1:0] prog_out_data;
    logic           busy;
    logic           done;
    logic           pass;
    logic           timeout;

    int n_checks = 0;
    int n_fail = 0;

    fpga_run_controller #(
        .MemoryElementWidth (MEW),
        .NIn                (NIN),
        .NOut               (NOUT),
        .MaxSteps           (MAXS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .prog_in_we    (prog_in_we),
        .prog_in_addr  (prog_in_addr),
        .prog_in_data  (prog_in_data),
        .prog_reset    (prog_reset),
        .prog_finished (prog_finished),
        .prog_success  (prog_success),
        .prog_out_addr (prog_out_addr),
        .prog_out_data (prog_out_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Executor model: inMem written by the strobe; program emits (count, value) pairs.
    logic [MEW-1:0] in_mem [NIN];
    int   step_cnt = 0;
    logic fin_en = 1'b0;
    int   fin_step = 1;
    logic fin_success = 1'b0;
    int   cyc = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (prog_in_we && int'(prog_in_addr) < NIN) in_mem[int'(prog_in_addr)] <= prog_in_data;
        if (prog_reset) step_cnt <= 1;
        else step_cnt <= step_cnt + 1;
    end

    assign prog_finished = fin_en && !prog_reset && (step_cnt >= fin_step);
    assign prog_success  = fin_success;

    always_comb begin
        prog_out_data = '0;
        if (prog_out_addr[0] == 1'b0) prog_out_data = MEW'(NIN - int'(prog_out_addr) / 2);
        else if (int'(prog_out_addr) / 2 < NIN) prog_out_data = in_mem[int'(prog_out_addr) / 2];
    end

    // Monitor: records beats and event cycles, checks stall hold and reset outputs.
    logic [MEW-1:0] got_q[$];
    int   we_q[$];
    int   last_we_cyc = -1;
    int   start_cyc = -1;
    int   first_ov_cyc = -1;
    int   done_cyc = -1;
    logic done_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [MEW-1:0] hold_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            check_eq("rst_prog_reset", prog_reset, 1);
            check_eq("rst_outputs", {busy, done, pass, timeout, in_ready, out_valid, prog_in_we}, 0);
        end
        if (stall_prev) begin
            check_eq("stall_valid_held", out_valid, 1);
            check_eq("stall_data_held", out_data, hold_data);
        end
        stall_prev = out_valid && !out_ready;
        hold_data  = out_data;
        if (prog_in_we) begin
            we_q.push_back(int'(prog_in_addr));
            last_we_cyc = cyc;
        end
        if (prog_reset && !reset) begin
            start_cyc    = cyc;
            first_ov_cyc = -1;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    int ready_mode = 0;
    int pidx = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            pidx++;
            case (ready_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check_eq("start_in_ready", in_ready, 1);
        check_eq("start_busy", busy, 1);
        check_eq("start_clears_done", done, 0);
        check_eq("start_clears_pass", pass, 0);
        @(posedge clock); #1;
    endtask

    task automatic do_load(input logic [MEW-1:0] w0, input logic [MEW-1:0] w1,
                           input logic [MEW-1:0] w2, input int gap, input logic start_in_load);
        logic [MEW-1:0] w [NIN];
        int budget;
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int k = 0; k < NIN; k++) begin
            for (int g = 0; g < gap; g++) begin
                start = start_in_load && (k == 1) && (g == 0);
                @(posedge clock); #1;
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = w[k];
            budget   = 0;
            @(negedge clock);
            while (!in_ready && budget < 50) begin
                @(negedge clock);
                budget++;
            end
            check_eq("load_ready", in_ready, 1);
            @(posedge clock); #1;
            in_valid = 1'b0;
            in_data  = MEW'($urandom);
        end
    endtask

    task automatic finish_check(input logic [MEW-1:0] w0, input logic [MEW-1:0] w1,
                                input logic [MEW-1:0] w2, input int fstep, input logic succ,
                                input int got_base, input int we_base);
        logic [MEW-1:0] w [NIN];
        logic [MEW-1:0] exp_q[$];
        int budget = 0;
        w[0] = w0; w[1] = w1; w[2] = w2;
        for (int k = 0; k < NIN; k++) begin
            exp_q.push_back(MEW'(NIN - k));
            exp_q.push_back(w[k]);
        end
        @(negedge clock);
        while (!done && budget < 500) begin
            @(negedge clock);
            budget++;
        end
        check_eq("done_reached", done, 1);
        check_eq("pass_value", pass, succ);
        check_eq("timeout_low", timeout, 0);
        check_eq("we_count", we_q.size() - we_base, NIN);
        for (int i = 0; i < NIN; i++)
            if (we_base + i < we_q.size()) check_eq("we_addr", we_q[we_base + i], i);
        check_eq("start_after_last_we", start_cyc - last_we_cyc, 1);
        check_eq("run_latency", first_ov_cyc - start_cyc, fstep + 1);
        check_eq("out_beats", got_q.size() - got_base, NOUT);
        for (int i = 0; i < NOUT; i++)
            if (got_base + i < got_q.size()) check_eq("out_word", got_q[got_base + i], exp_q[i]);
        repeat (3) @(negedge clock);
        check_eq("done_hold", done, 1);
        check_eq("pass_hold", pass, succ);
        @(posedge clock); #1;
    endtask

    task automatic run_once(input logic [MEW-1:0] w0, input logic [MEW-1:0] w1,
                            input logic [MEW-1:0] w2, input int fstep, input logic succ,
                            input int gap, input logic start_in_load, input int rmode);
        int got_base = got_q.size();
        int we_base = we_q.size();
        fin_en = 1'b1; fin_step = fstep; fin_success = succ; ready_mode = rmode;
        do_start();
        do_load(w0, w1, w2, gap, start_in_load);
        finish_check(w0, w1, w2, fstep, succ, got_base, we_base);
    endtask

    initial begin
        int budget;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("idle_after_reset", {busy, done, pass, timeout, in_ready, out_valid, prog_reset}, 0);
        @(posedge clock); #1;

        // Basic run, stalled drain, gapped load, start ignored in LOAD then restart from DONE.
        run_once(12'd33, 12'd22, 12'd11, 5, 1'b1, 0, 1'b0, 0);
        run_once(12'd7, 12'd300, 12'd4095, 3, 1'b1, 0, 1'b0, 2);
        run_once(12'd1, 12'd2, 12'd3, 8, 1'b0, 2, 1'b0, 0);
        run_once(12'd100, 12'd200, 12'd300, 4, 1'b1, 1, 1'b1, 1);

        for (int r = 0; r < 6; r++)
            run_once(MEW'($urandom), MEW'($urandom), MEW'($urandom), $urandom_range(1, 12),
                     1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, $urandom_range(0, 2));

        // Reset in RUN at step 10, then an identical rerun.
        fin_en = 1'b1; fin_step = 14; fin_success = 1'b1; ready_mode = 0;
        do_start();
        do_load(12'd5, 12'd6, 12'd7, 0, 1'b0);
        budget = 0;
        @(negedge clock);
        while (cyc - start_cyc != 10 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        check_eq("t4_in_run", {busy, prog_reset}, 2'b10);
        #1 reset = 1'b1;
        @(negedge clock);
        check_eq("t4_reset_busy", busy, 0);
        check_eq("t4_reset_prog_reset", prog_reset, 1);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_eq("t4_idle", {busy, done, in_ready, prog_reset}, 0);
        @(posedge clock); #1;
        run_once(12'd5, 12'd6, 12'd7, 14, 1'b1, 0, 1'b0, 0);

        // Start and reset together: reset wins.
        reset = 1'b1; start = 1'b1;
        @(posedge clock); #1 start = 1'b0; reset = 1'b0;
        @(negedge clock);
        check_eq("rst_start_idle", {busy, done, in_ready}, 0);
        @(posedge clock); #1;

`ifdef FPGA_CTRL_WATCHDOG_EN
        // Finish on the last allowed step wins over the watchdog.
        run_once(12'd9, 12'd8, 12'd7, MAXS, 1'b1, 0, 1'b0, 0);
        // Executor never finishes: timeout after MAXS RUN cycles, no drain.
        fin_en = 1'b0; ready_mode = 0;
        do_start();
        do_load(12'd1, 12'd1, 12'd1, 0, 1'b0);
        budget = 0;
        @(negedge clock);
        while (!done && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        check_eq("wd_done", done, 1);
        check_eq("wd_timeout", timeout, 1);
        check_eq("wd_pass", pass, 0);
        check_eq("wd_latency", done_cyc - start_cyc, MAXS + 1);
        check_eq("wd_no_out_valid", first_ov_cyc, 32'hFFFF_FFFF);
        @(posedge clock); #1;
        do_start();
        check_eq("wd_start_clears_timeout", timeout, 0);
`else
        // Without the watchdog RUN waits indefinitely.
        fin_en = 1'b0; ready_mode = 0;
        do_start();
        do_load(12'd1, 12'd1, 12'd1, 0, 1'b0);
        repeat (60) @(negedge clock);
        check_eq("run_waits_busy", busy, 1);
        check_eq("run_waits_no_done", {done, timeout, out_valid}, 0);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_eq("run_waits_reset_idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
